step_dir_decoder: RTL and testbench
===================================

Name: step_dir_decoder

Overview:
- Receive side of the up/down step counter interface.
- Observes sampled count values and recovers the per-step command: hold/up/down, plus the equivalent en/dir pair.
- Tracks run length and flags illegal jumps, then resynchronises.
- Sits downstream of the counter, or across a sampled link, for monitoring and replay.

Parameters:
- W, 4, count width; legal range 2..16 (W=1 is illegal because +1 and -1 are the same step).
- RUN_W, 8, width of the run-length counter; saturating.
- ERR_W, 4, width of the error counter; saturating.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear: returns to UNSYNC and zeroes both counters; takes priority over valid.
- valid  in  1  q_in holds a new sample this cycle.
- q_in  in  W  sampled count value.
- state  out  2  decoded step: 0=hold, 1=up, 2=down, 3=illegal jump.
- en  out  1  recovered enable; 1 for up or down.
- dir  out  1  recovered direction; 1=up, 0=down or hold.
- out_valid  out  1  one-cycle strobe: state, en and dir are new.
- synced  out  1  a reference value is held.
- run_len  out  RUN_W  consecutive samples carrying the current state, counting the first as 1.
- err_cnt  out  ERR_W  illegal jumps seen since reset or clr.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; FSM=UNSYNC; stored reference ref=0.
- FSM states:
  - UNSYNC: on valid, ref<=q_in and go to TRACK. No classification, out_valid stays 0.
  - TRACK: on valid, classify using d = (q_in - ref) mod 2^W.
    - d=0 -> hold (state=0, en=0, dir=0).
    - d=1 -> up (state=1, en=1, dir=1).
    - d=2^W-1 -> down (state=2, en=1, dir=0).
    - any other d -> illegal (state=3, en=0, dir=0), err_cnt+1 (saturating), go to UNSYNC.
  - Every classified sample pulses out_valid and updates ref<=q_in, including illegal samples. An illegal sample therefore becomes the new reference, but the FSM still passes through UNSYNC.
- Correction to the UNSYNC-after-illegal case: after an illegal jump, the next valid sample is consumed by UNSYNC as the reference. This costs exactly one unclassified sample per error.
- Latency: outputs are registered; state/en/dir/out_valid appear the cycle after the valid sample. out_valid is 0 in every cycle without a classification.
- state/en/dir hold their last value between strobes.
- synced = (FSM==TRACK).
- run_len:
  - On each classification, if the new state equals the previous classified state and run_len>0, increment, saturating at 2^RUN_W-1.
  - Otherwise load 1.
  - An illegal sample loads 1 with state 3.
  - Leaving TRACK does not clear run_len; only the first classification after resync reloads it to 1.
- Wrap-around: ref=2^W-1 with q_in=0 is up; ref=0 with q_in=2^W-1 is down. Both are legal.
- Simultaneous events:
  - clr and valid in the same cycle: clr wins and the sample is dropped.
  - clr does not touch state/en/dir; it does zero out_valid for that cycle.
- valid held high continuously: one classification per cycle, no bubbles.
- Arithmetic: difference is computed modulo 2^W; no sign extension. Counter saturation is a compare-and-hold, never a wrap.

Decomposition:
- Shared package step_pkg:
  - step_e enum logic[1:0] {STEP_HOLD=0, STEP_UP=1, STEP_DOWN=2, STEP_ERR=3}. This is the same encoding the counter's state output uses.
  - dec_fsm_e {UNSYNC, TRACK}.
- One natural sub-module: sat_counter (parameter width; inputs clr, load1, inc; output count). Instantiate it twice, for run_len and err_cnt.
- Classification stays in the top as a combinational function of q_in and ref.

Test Plan:
- Reset/sync:
  - Stimulus: rst low, release; valid with q_in=5.
  - Response: all outputs 0, out_valid 0, synced=1 the next cycle.
  - Then q_in=6: state=1, en=1, dir=1, run_len=1.
- Up wrap, W=4:
  - Stimulus: samples E, F, 0, 1.
  - Response: after the first, three up classifications with run_len 1, 2, 3; no errors.
- Down then hold:
  - Stimulus: samples 1, 0, F, F, F.
  - Response: down, down (run_len 2), then hold (run_len 1), hold (run_len 2); en=0 on hold.
- Illegal jump:
  - Stimulus: samples 3, 4, 9, A, B.
  - Response: 4 gives up; 9 gives state=3, err_cnt=1, synced=0. A is unclassified (reference). B gives up, run_len=1.
- Saturation:
  - Stimulus: RUN_W=3, 10 consecutive holds.
  - Response: run_len reaches 7 and stays 7.
  - Stimulus: ERR_W=2, 5 illegal jumps.
  - Response: err_cnt=3.
- clr/async reset mid-run:
  - Stimulus: clr with valid in the same cycle.
  - Response: sample dropped, synced=0, run_len=0, err_cnt=0.
  - Stimulus: rst asserted between clock edges.
  - Response: outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/step_pkg.sv
// Shared types for the step/dir decoder.
//   step_e    : decoded step code, same encoding as the counter's state output
//   dec_fsm_e : decoder sync state
package step_pkg;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2,
    STEP_ERR  = 2'd3
  } step_e;

  typedef enum logic {
    UNSYNC = 1'b0,
    TRACK  = 1'b1
  } dec_fsm_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-one.
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the count (highest priority)
//   load1      : load the value 1
//   inc        : increment, holding at all-ones
//   count      : current value
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load1,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)                            count_d = '0;
    else if (load1)                     count_d = WIDTH'(1);
    else if (inc && (count_q != '1))    count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/step_dir_decoder.sv
// Recovers hold/up/down commands from sampled up/down counter values.
//   clk, rst      : clock, async active-low reset
//   clr           : sync clear to UNSYNC, zero counters (beats valid)
//   valid, q_in   : new sample strobe and sampled count
//   state/en/dir  : decoded step, held between strobes
//   out_valid     : one-cycle strobe when state/en/dir are new
//   synced        : a reference value is held
//   run_len       : length of the current run of equal states
//   err_cnt       : illegal jumps seen since reset/clr
module step_dir_decoder
  import step_pkg::*;
#(
  parameter int W     = 4,
  parameter int RUN_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             valid,
  input  logic [W-1:0]     q_in,
  output logic [1:0]       state,
  output logic             en,
  output logic             dir,
  output logic             out_valid,
  output logic             synced,
  output logic [RUN_W-1:0] run_len,
  output logic [ERR_W-1:0] err_cnt
);

  // Difference is taken modulo 2^W, so wrap-around steps are legal.
  function automatic step_e classify(input logic [W-1:0] q, input logic [W-1:0] r);
    logic [W-1:0] d;
    d = q - r;
    if (d == '0)             return STEP_HOLD;
    else if (d == W'(1))     return STEP_UP;
    else if (d == {W{1'b1}}) return STEP_DOWN;
    else                     return STEP_ERR;
  endfunction

  dec_fsm_e     fsm_q, fsm_d;
  logic [W-1:0] ref_q, ref_d;
  step_e        step_q, step_d;
  logic         en_q, en_d, dir_q, dir_d, ov_q, ov_d;
  // Set when a reference is captured; forces the first classification
  // after resync to start a new run even if it repeats the old state.
  logic         fresh_q, fresh_d;
  logic         cls;
  step_e        cls_step;
  logic         run_load1;

  always_comb begin
    fsm_d    = fsm_q;
    ref_d    = ref_q;
    step_d   = step_q;
    en_d     = en_q;
    dir_d    = dir_q;
    ov_d     = 1'b0;
    fresh_d  = fresh_q;
    cls      = 1'b0;
    cls_step = classify(q_in, ref_q);
    if (clr) begin
      fsm_d = UNSYNC;
    end else if (valid) begin
      ref_d = q_in;
      if (fsm_q == UNSYNC) begin
        fsm_d   = TRACK;
        fresh_d = 1'b1;
      end else begin
        cls     = 1'b1;
        ov_d    = 1'b1;
        fresh_d = 1'b0;
        step_d  = cls_step;
        en_d    = (cls_step == STEP_UP) || (cls_step == STEP_DOWN);
        dir_d   = (cls_step == STEP_UP);
        if (cls_step == STEP_ERR) fsm_d = UNSYNC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q   <= UNSYNC;
      ref_q   <= '0;
      step_q  <= STEP_HOLD;
      en_q    <= 1'b0;
      dir_q   <= 1'b0;
      ov_q    <= 1'b0;
      fresh_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      ref_q   <= ref_d;
      step_q  <= step_d;
      en_q    <= en_d;
      dir_q   <= dir_d;
      ov_q    <= ov_d;
      fresh_q <= fresh_d;
    end
  end

  assign run_load1 = cls && (fresh_q || (cls_step != step_q) || (run_len == '0));

  sat_counter #(.WIDTH(RUN_W)) u_run (
    .clk   (clk),
    .rst_n (rst),
    .clr   (clr),
    .load1 (run_load1),
    .inc   (cls && !run_load1),
    .count (run_len)
  );

  sat_counter #(.WIDTH(ERR_W)) u_err (
    .clk   (clk),
    .rst_n (rst),
    .clr   (clr),
    .load1 (1'b0),
    .inc   (cls && (cls_step == STEP_ERR)),
    .count (err_cnt)
  );

  assign state     = step_q;
  assign en        = en_q;
  assign dir       = dir_q;
  assign out_valid = ov_q;
  assign synced    = (fsm_q == TRACK);

endmodule

// File: tb/tb_step_dir_decoder.sv
// Directed-vector bench for step_dir_decoder (W=4, RUN_W=3, ERR_W=2).
module tb_step_dir_decoder;

  localparam int W = 4, RUN_W = 3, ERR_W = 2;

  logic clk = 1'b0, rst = 1'b0, clr = 1'b0, valid = 1'b0;
  logic [W-1:0]     q_in = '0;
  logic [1:0]       state;
  logic             en, dir, out_valid, synced;
  logic [RUN_W-1:0] run_len;
  logic [ERR_W-1:0] err_cnt;

  int errors = 0, checks = 0;

  step_dir_decoder #(.W(W), .RUN_W(RUN_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .valid(valid), .q_in(q_in),
    .state(state), .en(en), .dir(dir), .out_valid(out_valid),
    .synced(synced), .run_len(run_len), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       c, v;
    logic [3:0] q;
    logic [1:0] st;
    logic       en, dir, ov, sy;
    logic [2:0] rl;
    logic [1:0] ec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic c, logic v, logic [3:0] q, logic [1:0] st, logic e,
                              logic d, logic ov, logic sy, logic [2:0] rl, logic [1:0] ec);
    vec_t r;
    r.c = c; r.v = v; r.q = q; r.st = st; r.en = e; r.dir = d;
    r.ov = ov; r.sy = sy; r.rl = rl; r.ec = ec;
    return r;
  endfunction

  // Packed view: {state, en, dir, out_valid, synced, run_len, err_cnt}
  function automatic logic [10:0] pack(vec_t x);
    return {x.st, x.en, x.dir, x.ov, x.sy, x.rl, x.ec};
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got st/en/dir/ov/sy/rl/ec=%b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [10:0] dut_out();
    return {state, en, dir, out_valid, synced, run_len, err_cnt};
  endfunction

  initial begin
    // reset / sync / first up
    vecs.push_back(mk(0,1,4'h5, 0,0,0,0,1, 0,0));
    vecs.push_back(mk(0,1,4'h6, 1,1,1,1,1, 1,0));
    // clr with valid: sample dropped, state/en/dir untouched
    vecs.push_back(mk(1,1,4'hE, 1,1,1,0,0, 0,0));
    // up wrap E,F,0,1
    vecs.push_back(mk(0,1,4'hE, 1,1,1,0,1, 0,0));
    vecs.push_back(mk(0,1,4'hF, 1,1,1,1,1, 1,0));
    vecs.push_back(mk(0,1,4'h0, 1,1,1,1,1, 2,0));
    vecs.push_back(mk(0,1,4'h1, 1,1,1,1,1, 3,0));
    // down, down, hold, hold
    vecs.push_back(mk(0,1,4'h0, 2,1,0,1,1, 1,0));
    vecs.push_back(mk(0,1,4'hF, 2,1,0,1,1, 2,0));
    vecs.push_back(mk(0,1,4'hF, 0,0,0,1,1, 1,0));
    vecs.push_back(mk(0,1,4'hF, 0,0,0,1,1, 2,0));
    // run_len saturation at 7
    for (int i = 3; i <= 10; i++)
      vecs.push_back(mk(0,1,4'hF, 0,0,0,1,1, (i > 7) ? 3'd7 : 3'(i), 0));
    // clr without valid
    vecs.push_back(mk(1,0,4'h0, 0,0,0,0,0, 0,0));
    // illegal jump sequence 3,4,9,A,B
    vecs.push_back(mk(0,1,4'h3, 0,0,0,0,1, 0,0));
    vecs.push_back(mk(0,1,4'h4, 1,1,1,1,1, 1,0));
    vecs.push_back(mk(0,1,4'h9, 3,0,0,1,0, 1,1));
    vecs.push_back(mk(0,1,4'hA, 3,0,0,0,1, 1,1));
    vecs.push_back(mk(0,1,4'hB, 1,1,1,1,1, 1,1));
    // idle cycle: everything holds, no strobe
    vecs.push_back(mk(0,0,4'h0, 1,1,1,0,1, 1,1));
    // repeated illegal jumps: err_cnt saturates at 3, each restarts run at 1
    vecs.push_back(mk(0,1,4'h5, 3,0,0,1,0, 1,2));
    vecs.push_back(mk(0,1,4'h5, 3,0,0,0,1, 1,2));
    vecs.push_back(mk(0,1,4'h0, 3,0,0,1,0, 1,3));
    vecs.push_back(mk(0,1,4'h0, 3,0,0,0,1, 1,3));
    vecs.push_back(mk(0,1,4'h8, 3,0,0,1,0, 1,3));
    vecs.push_back(mk(0,1,4'h8, 3,0,0,0,1, 1,3));
    // down by one after resync
    vecs.push_back(mk(0,1,4'h7, 2,1,0,1,1, 1,3));

    repeat (2) @(posedge clk);
    #1 check("reset", dut_out(), 11'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1 check("post_reset_idle", dut_out(), 11'b0);

    foreach (vecs[i]) begin
      @(negedge clk);
      clr = vecs[i].c; valid = vecs[i].v; q_in = vecs[i].q;
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), dut_out(), pack(vecs[i]));
    end

    // async reset between edges clears outputs without a clock edge
    @(negedge clk) begin clr = 1'b0; valid = 1'b0; end
    @(posedge clk) #3 rst = 1'b0;
    #1 check("async_reset", dut_out(), 11'b0);
    @(negedge clk) rst = 1'b1;
    // first sample after reset is only a reference
    valid = 1'b1; q_in = 4'hF;
    @(posedge clk) #1 check("resync_ref", dut_out(), {2'd0,1'b0,1'b0,1'b0,1'b1,3'd0,2'd0});
    @(negedge clk) q_in = 4'h0;
    @(posedge clk) #1 check("wrap_up_after_reset", dut_out(), {2'd1,1'b1,1'b1,1'b1,1'b1,3'd1,2'd0});
    @(negedge clk) valid = 1'b0;
    @(posedge clk) #1 check("strobe_drops", dut_out(), {2'd1,1'b1,1'b1,1'b0,1'b1,3'd1,2'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
